// File: rtl/aer_frame_streamer_if.sv
// Frame-buffer read port, AER 4-phase handshake and scan control/status of the frame streamer.
interface aer_frame_streamer_if #(
  parameter int ADDR_WIDTH = 17,
  parameter int AER_WIDTH  = 11,
  parameter int CNT_WIDTH  = 20
);
  logic                  start;
  logic                  abort;
  logic                  read_data_neg;
  logic                  read_data_pos;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  aer_nack;
  logic                  aer_nreq;
  logic [AER_WIDTH-1:0]  aer_data;
  logic                  busy;
  logic                  done;
  logic                  timeout_err;
  logic [CNT_WIDTH-1:0]  event_count;

  modport master (
    input  start, abort, read_data_neg, read_data_pos, aer_nack,
    output addr, aer_nreq, aer_data, busy, done, timeout_err, event_count
  );

  modport slave (
    output start, abort, read_data_neg, read_data_pos, aer_nack,
    input  addr, aer_nreq, aer_data, busy, done, timeout_err, event_count
  );
endinterface

// File: rtl/aer_frame_streamer.sv
// Scans a polarity frame row-major and emits row/column AER words over a 4-phase nreq/nack handshake.
// Handshake outputs are registered so nreq never glitches; abort is deferred while a word is in flight.
module aer_frame_streamer #(
  parameter int X_LENGTH     = 320,
  parameter int Y_DEPTH      = 240,
  parameter int X_ADDR_WIDTH = 9,
  parameter int Y_ADDR_WIDTH = 8,
  parameter int ADDR_WIDTH   = 17,
  parameter int AER_WIDTH    = 11,
  parameter int MEM_LAT      = 1,
  parameter int Y_FLIP       = 1,
  parameter int SKIP_EMPTY   = 0,
  parameter int TIMEOUT_CYC  = 65535,
  parameter int CNT_WIDTH    = 20
) (
  input logic                  clk,
  input logic                  rst,
  aer_frame_streamer_if.master bus
);

  localparam logic [X_ADDR_WIDTH-1:0] X_LAST    = X_ADDR_WIDTH'(X_LENGTH - 1);
  localparam logic [Y_ADDR_WIDTH-1:0] Y_LAST    = Y_ADDR_WIDTH'(Y_DEPTH - 1);
  localparam logic [2:0]              LAT_LAST  = 3'(MEM_LAT - 1);
  localparam int                      TO_LAST_I = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
  localparam logic [16:0]             TO_LAST   = 17'(TO_LAST_I);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_EVAL, S_ROW_SETUP, S_COL_SETUP, S_REQ, S_ACK, S_ADVANCE, S_DONE
  } state_t;

  state_t                  state, state_nxt;
  logic [X_ADDR_WIDTH-1:0] x;
  logic [Y_ADDR_WIDTH-1:0] y;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [2:0]              lat_cnt;
  logic [16:0]             to_cnt;
  logic                    neg_r, pos_r, row_owed, is_row, pol, abort_pend;
  logic [AER_WIDTH-1:0]    aer_data_q;
  logic                    nreq_q, busy_q, done_q, terr_q;
  logic [CNT_WIDTH-1:0]    cnt_q;

  logic pix_act, lat_done, to_hit, last_x, last_pix, stop_req, row_send, more_col;
  logic start_acc, ld_row, ld_col, col_pol, cnt_inc, to_fire, hs_entry;
  logic nreq_nxt, busy_nxt, done_nxt;

  function automatic logic [AER_WIDTH-1:0] row_word(input logic [Y_ADDR_WIDTH-1:0] yy);
    logic [AER_WIDTH-1:0] w;
    w = '0;
    w[Y_ADDR_WIDTH-1:0] = (Y_FLIP != 0) ? Y_LAST - yy : yy;
    return w;
  endfunction

  function automatic logic [AER_WIDTH-1:0] col_word(input logic [X_ADDR_WIDTH-1:0] xx, input logic p);
    logic [AER_WIDTH-1:0] w;
    w = '0;
    w[AER_WIDTH-1]      = 1'b1;
    w[X_ADDR_WIDTH:1]   = xx;
    w[0]                = p;
    return w;
  endfunction

  assign pix_act  = bus.read_data_neg | bus.read_data_pos;
  assign lat_done = (lat_cnt == LAT_LAST);
  assign to_hit   = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST);
  assign last_x   = (x == X_LAST);
  assign last_pix = last_x && (y == Y_LAST);
  assign stop_req = abort_pend | bus.abort;
  assign row_send = row_owed && (pix_act || (SKIP_EMPTY == 0));
  // A row word may precede an empty pixel (SKIP_EMPTY=0), so check the latched polarities.
  assign more_col = is_row ? (neg_r | pos_r) : (!pol && pos_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (bus.start) state_nxt = S_FETCH;
      S_FETCH:     if (bus.abort) state_nxt = S_IDLE;
                   else if (lat_done) state_nxt = S_EVAL;
      S_EVAL:      if (bus.abort) state_nxt = S_IDLE;
                   else if (row_send) state_nxt = S_ROW_SETUP;
                   else if (pix_act) state_nxt = S_COL_SETUP;
                   else state_nxt = S_ADVANCE;
      S_ROW_SETUP: state_nxt = S_REQ;
      S_COL_SETUP: state_nxt = S_REQ;
      S_REQ:       if (!bus.aer_nack) state_nxt = S_ACK;
                   else if (to_hit) state_nxt = S_IDLE;
      S_ACK:       if (bus.aer_nack) begin
                     if (stop_req) state_nxt = S_IDLE;
                     else if (more_col) state_nxt = S_COL_SETUP;
                     else state_nxt = S_ADVANCE;
                   end else if (to_hit) state_nxt = S_IDLE;
      S_ADVANCE:   if (bus.abort) state_nxt = S_IDLE;
                   else if (last_pix) state_nxt = S_DONE;
                   else state_nxt = S_FETCH;
      S_DONE:      state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    start_acc = (state == S_IDLE) && bus.start;
    ld_row    = (state == S_EVAL) && (state_nxt == S_ROW_SETUP);
    ld_col    = (state_nxt == S_COL_SETUP) && (state != S_COL_SETUP);
    col_pol   = (state == S_EVAL) ? !bus.read_data_neg : (is_row ? !neg_r : 1'b1);
    cnt_inc   = (state == S_ACK) && bus.aer_nack && !is_row;
    to_fire   = to_hit && (((state == S_REQ) && bus.aer_nack) || ((state == S_ACK) && !bus.aer_nack));
    hs_entry  = ((state_nxt == S_REQ) || (state_nxt == S_ACK)) && (state_nxt != state);
    nreq_nxt  = (state_nxt != S_REQ);
    busy_nxt  = (state_nxt != S_IDLE);
    done_nxt  = (state_nxt == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0; y <= '0; addr_q <= '0; lat_cnt <= '0; to_cnt <= '0;
      neg_r <= 1'b0; pos_r <= 1'b0; row_owed <= 1'b0; is_row <= 1'b0; pol <= 1'b0;
      abort_pend <= 1'b0; aer_data_q <= '0; nreq_q <= 1'b1; busy_q <= 1'b0;
      done_q <= 1'b0; terr_q <= 1'b0; cnt_q <= '0;
    end else begin
      nreq_q <= nreq_nxt;
      busy_q <= busy_nxt;
      done_q <= done_nxt;
      if (start_acc) begin
        x <= '0; y <= '0; addr_q <= '0; row_owed <= 1'b1;
        terr_q <= 1'b0; cnt_q <= '0;
      end
      if ((state_nxt == S_FETCH) && (state != S_FETCH)) lat_cnt <= '0;
      else if (state == S_FETCH) lat_cnt <= lat_cnt + 3'd1;
      if (state == S_EVAL) begin
        neg_r <= bus.read_data_neg;
        pos_r <= bus.read_data_pos;
      end
      if (ld_row) begin
        aer_data_q <= row_word(y);
        is_row     <= 1'b1;
        row_owed   <= 1'b0;
      end
      if (ld_col) begin
        aer_data_q <= col_word(x, col_pol);
        is_row     <= 1'b0;
        pol        <= col_pol;
      end
      if (hs_entry) to_cnt <= '0;
      else if ((state == S_REQ) || (state == S_ACK)) to_cnt <= to_cnt + 17'd1;
      if (cnt_inc && (cnt_q != '1)) cnt_q <= cnt_q + CNT_WIDTH'(1);
      if (to_fire) terr_q <= 1'b1;
      // Abort seen while a word is in flight is held until the handshake closes.
      if (state_nxt == S_IDLE || start_acc) abort_pend <= 1'b0;
      else if (bus.abort && ((state == S_ROW_SETUP) || (state == S_COL_SETUP) ||
                             (state == S_REQ) || (state == S_ACK))) abort_pend <= 1'b1;
      if ((state == S_ADVANCE) && (state_nxt == S_FETCH)) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (last_x) begin
          x <= '0;
          y <= y + Y_ADDR_WIDTH'(1);
          row_owed <= 1'b1;
        end else begin
          x <= x + X_ADDR_WIDTH'(1);
        end
      end
      if (state == S_DONE) begin
        x <= '0; y <= '0; addr_q <= '0;
      end
    end
  end

  assign bus.addr        = addr_q;
  assign bus.aer_nreq    = nreq_q;
  assign bus.aer_data    = aer_data_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.timeout_err = terr_q;
  assign bus.event_count = cnt_q;

endmodule
